// File: rtl/eth_pkg.sv
// eth_pkg: shared constants, filter state encoding and buffer entry type
// for the eth_rx_filter destination-MAC filter.
package eth_pkg;

    localparam int                MAC_W     = 48;
    localparam logic [MAC_W-1:0]  BCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam int                HDR_LEN   = 6;
    localparam int                CNT_W     = 16;
    localparam int                HIDX_W    = 3;
    localparam logic [HIDX_W-1:0] HDR_LAST  = 3'(HDR_LEN - 1);

    typedef enum logic [1:0] {
        HDR,
        PASS,
        DROP
    } filt_state_t;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } buf_entry_t;

    // Header byte idx of a MAC address in wire order (byte 0 is bits 47:40).
    function automatic logic [7:0] mac_byte(input logic [MAC_W-1:0]  mac,
                                            input logic [HIDX_W-1:0] idx);
        logic [MAC_W-1:0] sh;
        sh = mac << (8 * idx);
        return sh[MAC_W-1 -: 8];
    endfunction

endpackage

// File: rtl/rewind_buf.sv
// rewind_buf: byte buffer with write, commit and read pointers. Only bytes
// behind the commit pointer are readable; a rewind discards uncommitted bytes.
module rewind_buf
    import eth_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       we,
    input  buf_entry_t wdata,
    input  logic       commit,
    input  logic       rewind,
    input  logic       re,
    output buf_entry_t rdata,
    output logic       full,
    output logic       avail
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_DIST = (AW + 1)'(DEPTH);

    buf_entry_t  r_mem [DEPTH];
    logic [AW:0] r_wr;
    logic [AW:0] r_cm;
    logic [AW:0] r_rd;

    logic        w_wr_ok;
    logic [AW:0] w_wr_next;

    assign full      = (r_wr - r_rd) == FULL_DIST;
    assign avail     = r_rd != r_cm;
    assign w_wr_ok   = we && !full;
    assign w_wr_next = r_wr + (AW + 1)'(w_wr_ok);
    assign rdata     = r_mem[r_rd[AW-1:0]];

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr[AW-1:0]] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every pointer sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr <= '0;
            r_cm <= '0;
            r_rd <= '0;
        end else begin
            r_wr <= rewind ? r_cm : w_wr_next;
            if (commit) begin
                r_cm <= w_wr_next;
            end
            if (re && avail) begin
                r_rd <= r_rd + 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_rx_filter.sv
// eth_rx_filter: forwards frames whose destination MAC is local, broadcast or
// promiscuous; others are discarded whole. ETH_FILTER_MCAST_EN also accepts group addresses.
module eth_rx_filter
    import eth_pkg::*;
#(
    parameter logic [MAC_W-1:0] MAC   = 48'h02_00_00_00_00_01,
    parameter int               DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_vld,
    input  logic             in_last,
    input  logic [7:0]       in_data,
    input  logic             promisc,
    output logic             out_vld,
    output logic             out_last,
    output logic [7:0]       out_data,
    output logic [CNT_W-1:0] cnt_accept,
    output logic [CNT_W-1:0] cnt_drop,
    output logic             overflow
);

    filt_state_t       r_state;
    logic [HIDX_W-1:0] r_hidx;
    logic              r_ucast_ok;
    logic              r_bcast_ok;
    logic [CNT_W-1:0]  r_cnt_accept;
    logic [CNT_W-1:0]  r_cnt_drop;

    logic       w_ucast;
    logic       w_bcast;
    logic       w_mcast;
    logic       w_match;
    logic       w_hdr_byte;
    logic       w_runt;
    logic       w_decide;
    logic       w_accept;
    logic       w_reject;
    logic       w_we;
    logic       w_commit;
    logic       w_rewind;
    logic       w_full;
    logic       w_avail;
    buf_entry_t w_wdata;
    buf_entry_t w_rdata;

    // Match flags include the byte currently on the input.
    assign w_ucast    = r_ucast_ok && (in_data == mac_byte(MAC, r_hidx));
    assign w_bcast    = r_bcast_ok && (in_data == mac_byte(BCAST_MAC, r_hidx));
    assign w_match    = promisc || w_ucast || w_bcast || w_mcast;

    assign w_hdr_byte = in_vld && (r_state == HDR);
    assign w_runt     = w_hdr_byte && in_last;
    assign w_decide   = w_hdr_byte && !in_last && (r_hidx == HDR_LAST);
    assign w_accept   = w_decide && w_match;
    assign w_reject   = w_decide && !w_match;

    assign w_we       = in_vld && (r_state != DROP);
    assign w_commit   = w_accept || (in_vld && (r_state == PASS));
    assign w_rewind   = w_runt || w_reject;
    assign w_wdata    = '{last: in_last, data: in_data};

`ifdef ETH_FILTER_MCAST_EN
    logic r_mcast;

    // Group bit is the LSB of the first destination byte.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_mcast <= 1'b0;
        end else if (w_hdr_byte && (r_hidx == '0)) begin
            r_mcast <= in_data[0];
        end
    end

    assign w_mcast = r_mcast;
`else
    assign w_mcast = 1'b0;
`endif

    rewind_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk    (clk),
        .resetn (resetn),
        .we     (w_we),
        .wdata  (w_wdata),
        .commit (w_commit),
        .rewind (w_rewind),
        .re     (w_avail),
        .rdata  (w_rdata),
        .full   (w_full),
        .avail  (w_avail)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= HDR;
            r_hidx     <= '0;
            r_ucast_ok <= 1'b1;
            r_bcast_ok <= 1'b1;
        end else if (in_vld) begin
            unique case (r_state)
                HDR: begin
                    if (in_last || (r_hidx == HDR_LAST)) begin
                        if (!in_last) begin
                            r_state <= w_match ? PASS : DROP;
                        end
                        r_hidx     <= '0;
                        r_ucast_ok <= 1'b1;
                        r_bcast_ok <= 1'b1;
                    end else begin
                        r_hidx     <= r_hidx + 1'b1;
                        r_ucast_ok <= w_ucast;
                        r_bcast_ok <= w_bcast;
                    end
                end
                PASS, DROP: begin
                    if (in_last) begin
                        r_state <= HDR;
                    end
                end
                default: r_state <= HDR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_vld      <= 1'b0;
            out_last     <= 1'b0;
            out_data     <= '0;
            r_cnt_accept <= '0;
            r_cnt_drop   <= '0;
            overflow     <= 1'b0;
        end else begin
            out_vld <= w_avail;
            if (w_avail) begin
                out_last <= w_rdata.last;
                out_data <= w_rdata.data;
            end
            if (w_accept && (r_cnt_accept != '1)) begin
                r_cnt_accept <= r_cnt_accept + 1'b1;
            end
            if ((w_runt || w_reject) && (r_cnt_drop != '1)) begin
                r_cnt_drop <= r_cnt_drop + 1'b1;
            end
            if (w_we && w_full) begin
                overflow <= 1'b1;
            end
        end
    end

    assign cnt_accept = r_cnt_accept;
    assign cnt_drop   = r_cnt_drop;

endmodule

// File: tb/tb_eth_rx_filter.sv
// Scoreboard bench for eth_rx_filter: expected bytes are queued as frames are
// driven and compared as the filter emits them. Build with ETH_FILTER_MCAST_EN to flip multicast.
module tb_eth_rx_filter;

    localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
    localparam int          GAP       = 4;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_vld = 1'b0;
    logic        in_last = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        promisc = 1'b0;
    logic        out_vld;
    logic        out_last;
    logic [7:0]  out_data;
    logic [15:0] cnt_accept;
    logic [15:0] cnt_drop;
    logic        overflow;

    exp_t        sb[$];
    logic [7:0]  frame[$];
    exp_t        e_out;
    int          n_checks = 0;
    int          n_pass = 0;
    int          exp_acc = 0;
    int          exp_drop = 0;

    eth_rx_filter #(
        .MAC   (LOCAL_MAC),
        .DEPTH (8)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_vld     (in_vld),
        .in_last    (in_last),
        .in_data    (in_data),
        .promisc    (promisc),
        .out_vld    (out_vld),
        .out_last   (out_last),
        .out_data   (out_data),
        .cnt_accept (cnt_accept),
        .cnt_drop   (cnt_drop),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (out_vld) begin
            if (sb.size() == 0) begin
                check("spurious_out_vld", 32'(out_vld), 32'd0);
            end else begin
                e_out = sb.pop_front();
                check("out_data", 32'(out_data), 32'(e_out.data));
                check("out_last", 32'(out_last), 32'(e_out.last));
            end
        end
    end

    function automatic bit model_accept(input bit pr);
        logic [47:0] hdr;
        if (frame.size() <= 6) return 1'b0;
        hdr = {frame[0], frame[1], frame[2], frame[3], frame[4], frame[5]};
        if (pr || hdr == LOCAL_MAC || hdr == 48'hFFFF_FFFF_FFFF) return 1'b1;
`ifdef ETH_FILTER_MCAST_EN
        if (frame[0][0]) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // One strobe followed by idle cycles; entered and left at posedge+1.
    task automatic drive_byte(input logic [7:0] d, input bit last);
        in_vld  = 1'b1;
        in_data = d;
        in_last = last;
        @(posedge clk); #1;
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send(input bit pr, input int clr_pr_after);
        bit   acc;
        exp_t e_in;
        acc     = model_accept(pr);
        promisc = pr;
        for (int i = 0; i < frame.size(); i++) begin
            if (acc) begin
                e_in.last = (i == frame.size() - 1);
                e_in.data = frame[i];
                sb.push_back(e_in);
            end
            drive_byte(frame[i], i == frame.size() - 1);
            if (i == clr_pr_after) promisc = 1'b0;
            repeat (GAP - 1) @(posedge clk);
            #1;
        end
        repeat (12) @(posedge clk);
        #1;
        if (acc) begin
            if (exp_acc < 65535) exp_acc++;
        end else begin
            if (exp_drop < 65535) exp_drop++;
        end
        check("cnt_accept", 32'(cnt_accept), exp_acc);
        check("cnt_drop", 32'(cnt_drop), exp_drop);
        check("drained", sb.size(), 0);
        promisc = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_vld", 32'(out_vld), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_cnt_accept", 32'(cnt_accept), 0);
        check("rst_cnt_drop", 32'(cnt_drop), 0);
        check("rst_overflow", 32'(overflow), 0);
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Unicast match, then mismatch, then a match again.
        frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hAA, 8'hBB};
        send(1'b0, -1);
        frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'hAA, 8'hBB};
        send(1'b0, -1);
        frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h10, 8'h20, 8'h30};
        send(1'b0, -1);

        // Broadcast, promiscuous, and promisc cleared after the decision byte.
        frame = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hCC};
        send(1'b0, -1);
        frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h55};
        send(1'b1, -1);
        frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC};
        send(1'b1, 5);

        // Runts: 4 bytes and exactly 6 bytes, then a match parsed from byte 0.
        frame = '{8'h02, 8'h00, 8'h00, 8'h00};
        send(1'b0, -1);
        frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        send(1'b0, -1);
        frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h77};
        send(1'b0, -1);

        // Multicast group address.
        frame = '{8'h01, 8'h00, 8'h5E, 8'h00, 8'h00, 8'h01, 8'hDD};
        send(1'b0, -1);

        // Reset right after the accept decision: nothing may come out.
        frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        for (int i = 0; i < 6; i++) begin
            drive_byte(frame[i], 1'b0);
            if (i < 5) begin
                repeat (GAP - 1) @(posedge clk);
                #1;
            end
        end
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out_vld", 32'(out_vld), 0);
        check("midrst_out_data", 32'(out_data), 0);
        check("midrst_cnt_accept", 32'(cnt_accept), 0);
        check("midrst_cnt_drop", 32'(cnt_drop), 0);
        resetn   = 1'b1;
        exp_acc  = 0;
        exp_drop = 0;
        repeat (20) @(posedge clk);
        #1;
        frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hE1, 8'hE2};
        send(1'b0, -1);

        // Drop counter saturation.
        force dut.r_cnt_drop = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.r_cnt_drop;
        exp_drop = 65535;
        frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h99};
        send(1'b0, -1);
        frame = '{8'h02, 8'h00};
        send(1'b0, -1);

        check("overflow_end", 32'(overflow), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
